// File: rtl/temp_threshold_monitor.sv
// Polls NUM_CH temperature sensors through an external I2C driver and raises
// filtered, hysteretic per-channel warnings. Define TEMP_MON_TIMEOUT_EN for a WAIT watchdog.
module temp_threshold_monitor #(
    parameter int NUM_CH         = 4,
    parameter int DATA_W         = 16,
    parameter int POLL_CYCLES    = 100000,
    parameter int FILT_N         = 3,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [DATA_W-1:0]        t_high,
    input  logic [DATA_W-1:0]        t_low,
    input  logic [DATA_W-1:0]        hyst,
    output logic                     cmd_start,
    output logic [CH_W-1:0]          cmd_ch,
    output logic [2:0]               cmd_reg,
    input  logic                     cmd_done,
    input  logic [DATA_W-1:0]        rd_data,
    output logic [NUM_CH*DATA_W-1:0] temp_bus,
    output logic                     sample_valid,
    output logic [NUM_CH-1:0]        warn_vec,
    output logic                     warning,
    output logic                     busy,
    output logic [NUM_CH-1:0]        err_vec
);

    localparam int GAP_W = $clog2(POLL_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_CYCLES - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [3:0]       FILT_MAX = 4'(FILT_N);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_GAP} state_t;

    state_t                        state_q, state_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [GAP_W-1:0]              gap_cnt_q, gap_cnt_d;
    logic                          cmd_start_q, cmd_start_d;
    logic                          sample_valid_q, sample_valid_d;
    logic                          busy_q, busy_d;
    logic                          warning_q, warning_d;
    logic [NUM_CH-1:0][DATA_W-1:0] temp_q, temp_d;
    logic [NUM_CH-1:0][3:0]        filt_q, filt_d;
    logic [NUM_CH-1:0]             warn_q, warn_d;

    // Threshold arithmetic is one bit wider than the data so t_high-hyst and
    // t_low+hyst cannot wrap around.
    logic signed [DATA_W:0] samp_x, hi_x, lo_x, hyst_x, hi_clr, lo_clr;
    logic                   out_range, is_clear;
    logic [3:0]             cur_cnt, cnt_next;

    assign samp_x    = {rd_data[DATA_W-1], rd_data};
    assign hi_x      = {t_high[DATA_W-1], t_high};
    assign lo_x      = {t_low[DATA_W-1], t_low};
    assign hyst_x    = {1'b0, hyst};
    assign hi_clr    = hi_x - hyst_x;
    assign lo_clr    = lo_x + hyst_x;
    assign out_range = (samp_x > hi_x) || (samp_x < lo_x);
    assign is_clear  = (samp_x >= lo_clr) && (samp_x <= hi_clr);
    assign cur_cnt   = filt_q[ch_q];
    assign cnt_next  = !out_range ? 4'd0 :
                       (cur_cnt >= FILT_MAX) ? FILT_MAX : cur_cnt + 4'd1;

`ifdef TEMP_MON_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [NUM_CH-1:0] err_q, err_d;
`endif

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        gap_cnt_d      = gap_cnt_q;
        cmd_start_d    = 1'b0;
        sample_valid_d = 1'b0;
        temp_d         = temp_q;
        filt_d         = filt_q;
        warn_d         = warn_q;
`ifdef TEMP_MON_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
        err_d          = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cmd_start_d = 1'b1;
                state_d     = S_WAIT;
`ifdef TEMP_MON_TIMEOUT_EN
                wait_cnt_d  = '0;
`endif
            end
            S_WAIT: begin
                // The sample is stored and judged on the cmd_done edge so that
                // sample_valid and the new warning appear together in EVAL.
                if (cmd_done) begin
                    temp_d[ch_q]   = rd_data;
                    filt_d[ch_q]   = cnt_next;
                    if (cnt_next == FILT_MAX)
                        warn_d[ch_q] = 1'b1;
                    else if (is_clear)
                        warn_d[ch_q] = 1'b0;
                    sample_valid_d = 1'b1;
                    state_d        = S_EVAL;
                end
`ifdef TEMP_MON_TIMEOUT_EN
                else if (wait_cnt_q == TO_LAST) begin
                    err_d[ch_q] = 1'b1;
                    state_d     = S_EVAL;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            S_EVAL: begin
                if (ch_q == LAST_CH) begin
                    ch_d      = '0;
                    gap_cnt_d = GAP_LOAD;
                    state_d   = S_GAP;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_GAP: begin
                // enable is only consulted here, so a round always completes.
                if (gap_cnt_q == '0)
                    state_d = enable ? S_ISSUE : S_IDLE;
                else
                    gap_cnt_d = gap_cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d    = (state_d != S_IDLE);
        warning_d = |warn_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            ch_q           <= '0;
            gap_cnt_q      <= '0;
            cmd_start_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            warning_q      <= 1'b0;
            temp_q         <= '0;
            filt_q         <= '0;
            warn_q         <= '0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            gap_cnt_q      <= gap_cnt_d;
            cmd_start_q    <= cmd_start_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            warning_q      <= warning_d;
            temp_q         <= temp_d;
            filt_q         <= filt_d;
            warn_q         <= warn_d;
        end
    end

`ifdef TEMP_MON_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            err_q      <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err_vec = err_q;
`else
    assign err_vec = '0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_bus
            assign temp_bus[gi*DATA_W +: DATA_W] = temp_q[gi];
        end
    endgenerate

    assign cmd_start    = cmd_start_q;
    assign cmd_ch       = ch_q;
    assign cmd_reg      = 3'd0;
    assign sample_valid = sample_valid_q;
    assign warn_vec     = warn_q;
    assign warning      = warning_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_temp_threshold_monitor.sv
// Directed bench for temp_threshold_monitor (2 channels, 10-cycle gap, filter of 3).
// Timeout scenario runs only when TEMP_MON_TIMEOUT_EN is defined.
module tb_temp_threshold_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] t_high, t_low, hyst;
    logic        cmd_start;
    logic [0:0]  cmd_ch;
    logic [2:0]  cmd_reg;
    logic        cmd_done;
    logic [15:0] rd_data;
    logic [31:0] temp_bus;
    logic        sample_valid;
    logic [1:0]  warn_vec;
    logic        warning;
    logic        busy;
    logic [1:0]  err_vec;

    int checks = 0;
    int errors = 0;

    temp_threshold_monitor #(
        .NUM_CH(2), .DATA_W(16), .POLL_CYCLES(10), .FILT_N(3), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .t_high(t_high), .t_low(t_low), .hyst(hyst),
        .cmd_start(cmd_start), .cmd_ch(cmd_ch), .cmd_reg(cmd_reg),
        .cmd_done(cmd_done), .rd_data(rd_data),
        .temp_bus(temp_bus), .sample_valid(sample_valid),
        .warn_vec(warn_vec), .warning(warning), .busy(busy), .err_vec(err_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!cmd_start && n < 200) begin
            step();
            n++;
        end
        if (!cmd_start) check("start_timeout", 0, 1);
    endtask

    // Act as the I2C driver for one request: answer two cycles after cmd_start.
    task automatic serve(input logic [15:0] data, input logic exp_ch);
        int n;
        wait_start(n);
        check("cmd_ch", cmd_ch, exp_ch);
        check("cmd_reg", cmd_reg, 0);
        step();
        step();
        rd_data  = data;
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
        rd_data  = '0;
        check("sample_valid", sample_valid, 1);
        $display("txn ch=%0d data=%h warn=%b temp_bus=%h", exp_ch, data, warn_vec, temp_bus);
    endtask

    initial begin
        int n;
        int starts;
        reset_n  = 1'b0;
        enable   = 1'b0;
        t_high   = 16'h0C80;
        t_low    = 16'h0000;
        hyst     = 16'h0080;
        cmd_done = 1'b0;
        rd_data  = '0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_cmd_start", cmd_start, 0);
        check("rst_warn", warn_vec, 0);
        check("rst_temp", temp_bus, 0);
        check("rst_err", err_vec, 0);
        reset_n = 1'b1;
        step();
        check("idle_busy", busy, 0);

        // Round robin, gap length and cmd_done ignored during GAP
        enable = 1'b1;
        serve(16'h0640, 1'b0);
        serve(16'h0640, 1'b1);
        check("rr_warn", warn_vec, 0);
        step();
        check("sv_one_cycle", sample_valid, 0);
        check("gap_busy", busy, 1);
        cmd_done = 1'b1;
        rd_data  = 16'h0D00;
        step();
        cmd_done = 1'b0;
        check("gap_done_ignored", sample_valid, 0);
        wait_start(n);
        check("gap_len", n, 10);
        serve(16'h0640, 1'b0);
        serve(16'h0640, 1'b1);
        check("rr_temp", temp_bus, 32'h0640_0640);
        check("rr_warn2", warn_vec, 0);

        // Filter: three out-of-range samples on ch0
        for (int r = 1; r <= 3; r++) begin
            serve(16'h0D00, 1'b0);
            check("filt_warn0", warn_vec[0], (r == 3) ? 1 : 0);
            serve(16'h0640, 1'b1);
        end
        check("filt_warning", warning, 1);
        check("filt_temp", temp_bus, 32'h0640_0D00);

        // Hysteresis band holds, clear sample releases
        serve(16'h0C40, 1'b0);
        check("hyst_hold", warn_vec[0], 1);
        serve(16'h0640, 1'b1);
        serve(16'h0BC0, 1'b0);
        check("hyst_clear", warn_vec[0], 0);
        check("hyst_warning", warning, 0);
        serve(16'h0640, 1'b1);

        // enable dropped mid-round: round finishes, GAP runs, then IDLE
        serve(16'h0640, 1'b0);
        enable = 1'b0;
        serve(16'h0640, 1'b1);
        repeat (10) step();
        check("dis_gap_busy", busy, 1);
        step();
        check("dis_idle", busy, 0);
        starts = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (cmd_start) starts++;
        end
        check("dis_no_start", starts, 0);

        // Negative temperature on ch1, signed compare below t_low
        enable = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            serve(16'h0640, 1'b0);
            serve(16'hFF00, 1'b1);
            check("neg_warn1", warn_vec[1], (r == 3) ? 1 : 0);
        end
        check("neg_temp", temp_bus, 32'hFF00_0640);
        check("neg_warning", warning, 1);

        // Asynchronous reset while waiting on the driver
        wait_start(n);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_cmd_start", cmd_start, 0);
        check("ar_busy", busy, 0);
        check("ar_warn", warn_vec, 0);
        check("ar_warning", warning, 0);
        check("ar_temp", temp_bus, 0);
        check("ar_cmd_ch", cmd_ch, 0);
        check("ar_err", err_vec, 0);
        enable = 1'b0;
        step();
        reset_n  = 1'b1;
        cmd_done = 1'b1;
        rd_data  = 16'h0D00;
        step();
        cmd_done = 1'b0;
        rd_data  = '0;
        check("late_done_sv", sample_valid, 0);
        check("late_done_busy", busy, 0);
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cmd_start || sample_valid) starts++;
        end
        check("post_rst_quiet", starts, 0);
        check("post_rst_temp", temp_bus, 0);

`ifdef TEMP_MON_TIMEOUT_EN
        // ch1 never answers: watchdog flags it and polling moves on
        enable = 1'b1;
        serve(16'h0640, 1'b0);
        wait_start(n);
        check("to_cmd_ch", cmd_ch, 1);
        repeat (19) step();
        check("to_err_early", err_vec, 0);
        step();
        check("to_err", err_vec, 2'b10);
        check("to_no_sv", sample_valid, 0);
        wait_start(n);
        check("to_next_ch", cmd_ch, 0);
        check("to_temp1", temp_bus[31:16], 0);
        check("to_err_sticky", err_vec, 2'b10);
`else
        check("err_const", err_vec, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
